// File: rtl/mac_bank_pkg.sv
// Shared types and arithmetic helpers for the multi-lane MAC bank.
// Every wide intermediate is MAX_W bits and signed, so rounding and clamping cannot overflow.
package mac_bank_pkg;

    localparam int MAX_W = 128;

    typedef logic signed [MAX_W-1:0] wide_t;

    // Per-lane stage-1 record; prod is already extended to MAX_W.
    typedef struct packed {
        wide_t prod;
        logic  first;
        logic  last;
    } s1_rec_t;

    function automatic wide_t sat_limit_hi(input int out_w, input bit signd);
        wide_t one;
        one = wide_t'(1);
        return signd ? (one <<< (out_w - 1)) - one : (one <<< out_w) - one;
    endfunction

    function automatic wide_t sat_limit_lo(input int out_w, input bit signd);
        wide_t one;
        one = wide_t'(1);
        return signd ? -(one <<< (out_w - 1)) : '0;
    endfunction

    // Round half up, then arithmetic shift. Unsigned sums are zero-extended first,
    // so the arithmetic shift behaves as a logical one for them.
    function automatic wide_t round_shift(input wide_t v, input int shift);
        wide_t one;
        one = wide_t'(1);
        if (shift <= 0)
            return v;
        return (v + (one <<< (shift - 1))) >>> shift;
    endfunction

endpackage

// File: rtl/mac_bank_pipelined_lane.sv
// One MAC lane: registered product, accumulator, and the round/shift/saturate
// logic that feeds the lane's held output register.
module mac_lane
    import mac_bank_pkg::*;
#(
    parameter int A_W    = 32,
    parameter int B_W    = 32,
    parameter int ACC_W  = 64,
    parameter int SHIFT  = 16,
    parameter int OUT_W  = 32,
    parameter int SIGNED = 1
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_clear,
    input  logic             i_s1_en,
    input  logic             i_s2_en,
    input  logic             i_first,
    input  logic             i_last,
    input  logic [A_W-1:0]   i_a,
    input  logic [B_W-1:0]   i_b,
    output logic [OUT_W-1:0] o_data,
    output logic             o_sat,
    output logic [ACC_W-1:0] o_acc
);

    localparam int P_W = A_W + B_W;

    logic [P_W-1:0]   w_prod;
    logic             w_prod_ext;
    s1_rec_t          w_rec_d;
    s1_rec_t          r_p1;
    logic [ACC_W-1:0] w_sum;
    logic [ACC_W-1:0] r_acc;
    logic             w_sum_ext;
    wide_t            w_sum_x;
    wide_t            w_r;
    wide_t            w_hi;
    wide_t            w_lo;
    wide_t            w_clamp;
    logic             w_sat;
    logic [OUT_W-1:0] r_data;
    logic             r_sat;
    logic             w_unused;

    // Operands are widened to the full product width before multiplying.
    always_comb begin
        if (SIGNED != 0)
            w_prod = $signed({{B_W{i_a[A_W-1]}}, i_a}) * $signed({{A_W{i_b[B_W-1]}}, i_b});
        else
            w_prod = {{B_W{1'b0}}, i_a} * {{A_W{1'b0}}, i_b};
    end

    assign w_prod_ext = (SIGNED != 0) ? w_prod[P_W-1] : 1'b0;

    always_comb begin
        w_rec_d       = '0;
        w_rec_d.prod  = {{(MAX_W-P_W){w_prod_ext}}, w_prod};
        w_rec_d.first = i_first;
        w_rec_d.last  = i_last;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            r_p1 <= '0;
        else if (i_s1_en)
            r_p1 <= w_rec_d;
    end

    assign w_sum = r_p1.first ? r_p1.prod[ACC_W-1:0] : r_acc + r_p1.prod[ACC_W-1:0];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            r_acc <= '0;
        else if (i_clear)
            r_acc <= '0;
        else if (i_s2_en)
            r_acc <= w_sum;
    end

    // The rounded result is taken from the sum being written this cycle, not the old acc.
    assign w_sum_ext = (SIGNED != 0) ? w_sum[ACC_W-1] : 1'b0;
    assign w_sum_x   = {{(MAX_W-ACC_W){w_sum_ext}}, w_sum};
    assign w_r       = round_shift(w_sum_x, SHIFT);
    assign w_hi      = sat_limit_hi(OUT_W, SIGNED != 0);
    assign w_lo      = sat_limit_lo(OUT_W, SIGNED != 0);

    always_comb begin
        w_clamp = w_r;
        w_sat   = 1'b0;
        if (w_r > w_hi) begin
            w_clamp = w_hi;
            w_sat   = 1'b1;
        end else if (w_r < w_lo) begin
            w_clamp = w_lo;
            w_sat   = 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_data <= '0;
            r_sat  <= 1'b0;
        end else if (i_clear) begin
            r_sat  <= 1'b0;
        end else if (i_s2_en && r_p1.last) begin
            r_data <= w_clamp[OUT_W-1:0];
            r_sat  <= w_sat;
        end
    end

    // Upper bits are pure sign/zero extension and never reach an output.
    assign w_unused = ^{r_p1.prod[MAX_W-1:ACC_W], w_clamp[MAX_W-1:OUT_W]};

    assign o_data = r_data;
    assign o_sat  = r_sat;
    assign o_acc  = r_acc;

endmodule

// File: rtl/mac_bank_pipelined.sv
// NUM_LANES MAC lanes behind one valid/ready input stream and one held output.
// Shared valid pipeline, stall and output handshake live here; datapath lives in mac_lane.
module mac_bank_pipelined
    import mac_bank_pkg::*;
#(
    parameter int NUM_LANES = 3,
    parameter int A_W       = 32,
    parameter int B_W       = 32,
    parameter int ACC_W     = 64,
    parameter int SHIFT     = 16,
    parameter int OUT_W     = 32,
    parameter int SIGNED    = 1
) (
    input  logic                         Clock_50,
    input  logic                         Resetn,
    input  logic                         clear,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic                         in_first,
    input  logic                         in_last,
    input  logic [NUM_LANES*A_W-1:0]     op_a,
    input  logic [NUM_LANES*B_W-1:0]     op_b,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [NUM_LANES*OUT_W-1:0]   out_data,
    output logic [NUM_LANES-1:0]         out_sat,
    output logic [NUM_LANES*ACC_W-1:0]   acc_dbg
);

    logic r_p1_valid;
    logic r_p1_last;
    logic r_out_valid;
    logic w_stall;
    logic w_accept;
    logic w_s2_en;
    logic w_res_load;

    assign w_stall    = r_out_valid & ~out_ready;
    // clear drains the output, so a beat offered with it is taken and dropped.
    assign in_ready   = clear | ~w_stall;
    assign w_accept   = in_valid & in_ready & ~clear;
    assign w_s2_en    = r_p1_valid & ~w_stall & ~clear;
    assign w_res_load = w_s2_en & r_p1_last;

    always_ff @(posedge Clock_50 or negedge Resetn) begin
        if (!Resetn) begin
            r_p1_valid  <= 1'b0;
            r_p1_last   <= 1'b0;
            r_out_valid <= 1'b0;
        end else if (clear) begin
            r_p1_valid  <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            if (!w_stall) begin
                r_p1_valid <= w_accept;
                r_p1_last  <= in_last;
            end
            if (w_res_load)
                r_out_valid <= 1'b1;
            else if (r_out_valid && out_ready)
                r_out_valid <= 1'b0;
        end
    end

    assign out_valid = r_out_valid;

    for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
        mac_lane #(
            .A_W    (A_W),
            .B_W    (B_W),
            .ACC_W  (ACC_W),
            .SHIFT  (SHIFT),
            .OUT_W  (OUT_W),
            .SIGNED (SIGNED)
        ) u_lane (
            .i_clk   (Clock_50),
            .i_rst_n (Resetn),
            .i_clear (clear),
            .i_s1_en (w_accept),
            .i_s2_en (w_s2_en),
            .i_first (in_first),
            .i_last  (in_last),
            .i_a     (op_a[g*A_W +: A_W]),
            .i_b     (op_b[g*B_W +: B_W]),
            .o_data  (out_data[g*OUT_W +: OUT_W]),
            .o_sat   (out_sat[g]),
            .o_acc   (acc_dbg[g*ACC_W +: ACC_W])
        );
    end

endmodule
